lens_spi_sequencer: RTL and testbench
=====================================

# lens_spi_sequencer

Two-requester transaction sequencer in front of the lens SPI driver. It arbitrates round-robin between requester 0 and requester 1, turns each granted request into one SPI frame, and loads the driver's TX-byte and command FIFOs in the order the driver needs. It tracks the driver's `busy` output until the frame completes, pops the received byte for reads, and returns a done pulse with read data or an error flag to the winning requester.

## Interface
- `WAIT_CYCLES`, default 16'd4: value driven on `spi_wait` with every command push; sets the inter-byte ACK gap in driver bit-periods.
- `START_TIMEOUT`, default 16: cycles allowed from the last command push to `spi_busy`=1 before the transaction is failed.
- `clk` in 1: system clock, shared with the SPI driver.
- `rst_n` in 1: synchronous, active-low reset.
- `req_0`, `req_1` in 1: transaction request; held high with its fields stable until the matching `done_*`.
- `rw_0`, `rw_1` in 1: 1 = register read, 0 = register write.
- `addr_0`, `addr_1` in 7: lens register address.
- `wdata_0`, `wdata_1` in 8: write data; ignored on reads.
- `done_0`, `done_1` out 1: one-cycle completion pulse.
- `rdata_0`, `rdata_1` out 8: read result; valid with `done_*` and held until the next done on that port.
- `err_0`, `err_1` out 1: qualified by `done_*`; 1 = start timeout.
- `spi_cmd_push` out 1: drives the driver's `command_read`.
- `spi_rw` out 2: 2'b01 = TX byte, 2'b10 = RX byte.
- `spi_wait` out 16: always `WAIT_CYCLES`.
- `spi_tx_push` out 1: drives the driver's `tx_read`.
- `spi_tx_data` out 8: byte written into the TX FIFO.
- `spi_rx_pop` out 1: drives the driver's `rx_read`.
- `spi_rx_data` in 8: the driver's `Spi_rx_reg`; valid the cycle after `spi_rx_pop`.
- `spi_busy` in 1: the driver's `busy`.

## Operation
- **States:** IDLE, LOAD, WAIT_START, WAIT_END, RX_POP, RX_CAP, FINISH.
- **IDLE:**
  - Grants only when `spi_busy`=0.
  - If both requests are high, the port not granted last wins.
  - `last_grant` resets to 1, so port 0 wins the first tie.
  - On grant, latch rw, addr and wdata, then go to LOAD.
- **Frame format:**
  - Byte 0 is always TX `{rw, addr[6:0]}`.
  - Write frames: byte 1 is TX `wdata`.
  - Read frames: byte 1 is RX.
- **LOAD push order (one strobe per cycle, TX data always pushed before any command):**
  - Write: tx `{0,addr}`, tx `wdata`, cmd 01, cmd 01. That is 4 cycles.
  - Read: tx `{1,addr}`, cmd 01, cmd 10. That is 3 cycles.
  - Every command push drives `spi_wait`=`WAIT_CYCLES`.
- **WAIT_START:**
  - Wait for `spi_busy`=1, then go to WAIT_END.
  - If `START_TIMEOUT` cycles pass without it, go to FINISH with err=1.
- **WAIT_END:** wait for `spi_busy`=0, meaning the driver is back in IDLE after end-of-frame. No timeout here.
  - Write: go to FINISH.
  - Read: go to RX_POP.
- **RX_POP:** `spi_rx_pop`=1 for one cycle.
- **RX_CAP:** capture `spi_rx_data` into `rdata_*`.
- **FINISH:**
  - Pulse `done_*` for one cycle with `err_*`.
  - Update `last_grant`, then return to IDLE.
- **Request re-sampling:** a requester that keeps `req` high after `done` is re-arbitrated in IDLE on the next cycle. There is no back-to-back bypass.
- **Requester drops `req` mid-transaction:** the frame still completes and `done` still pulses.
- **Reset:**
  - Reset mid-transaction returns the block to IDLE and clears all strobes.
  - The driver has no reset, so any in-flight frame finishes on its own; IDLE blocks the next grant until `spi_busy`=0.
  - Any stale RX byte left by an aborted read stays in the driver FIFO. Software must recover by issuing a dummy read.
- **Errors:** a timeout never issues `spi_rx_pop`, and `rdata_*` is unchanged.
- **Outstanding transactions:** one at a time. The driver FIFOs, 16 deep, therefore never hold more than 2 TX bytes and 2 commands, and overflow is impossible.

## Timing
- **Reset values:**
  - All strobes, `done_*` and `err_*` are 0.
  - `rdata_*` is 8'h00.
  - `spi_rw` is 2'b00, `spi_tx_data` is 8'h00, `spi_wait` is `WAIT_CYCLES`.
  - State is IDLE, `last_grant` is 1.
- **Grant:** the grant cycle is G, and the first LOAD strobe is at G+1.
- **Last push cycle:** G+4 for writes, G+3 for reads.
- **Driver start:** the driver's `busy` rises about 2 cycles after the first command push.
- **Strobes:** all strobes are registered and are exactly one cycle wide. At most one FIFO strobe is high per cycle.
- **Done latency:**
  - Write: `done` follows `spi_busy` falling by 2 cycles (WAIT_END, FINISH).
  - Read: `done` follows `spi_busy` falling by 4 cycles (RX_POP, RX_CAP, FINISH).
- **Read data:** `rdata_*` updates on the same edge that raises `done_*`.

## Test plan
- **Port-0 write:** write `addr`=7'h12, `wdata`=8'hA5 on port 0.
  - Required pushes, in order: tx 8'h12, tx 8'hA5, cmd 01, cmd 01.
  - Driver model shifts MOSI 0x12 then 0xA5.
  - `done_0`=1, `err_0`=0.
- **Port-1 read:** read `addr`=7'h05 on port 1, with the MISO model returning 8'h3C.
  - Required pushes: tx 8'h85, cmd 01, cmd 10.
  - `spi_rx_pop` fires once after `busy` falls.
  - `done_1` with `rdata_1`=8'h3C.
- **Tie arbitration:** raise `req_0` and `req_1` in the same cycle and hold both high.
  - Grants alternate 0, 1, 0, 1.
  - Only one frame is ever in flight, checked by counting `busy` high periods.
- **Start timeout:** hold `spi_busy` at 0 after the pushes.
  - `done_0` with `err_0`=1 exactly `START_TIMEOUT` cycles after the last push.
  - No `spi_rx_pop`; `rdata_0` unchanged.
- **Reset mid-frame:** pulse `rst_n` low for one cycle while `spi_busy`=1, with `req_1` held high.
  - All outputs return to reset values.
  - The next grant does not occur until `spi_busy`=0.
  - The following read returns the correct byte after one dummy read.

Source files
------------

// File: rtl/lens_spi_sequencer.sv
// Round-robin two-port sequencer that turns register requests into lens SPI frames.
// Loads the driver FIFOs, tracks busy to end of frame, pops RX for reads, returns done/err/rdata.
module lens_spi_sequencer #(
    parameter logic [15:0] WAIT_CYCLES   = 16'd4,
    parameter int          START_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_0,
    input  logic        req_1,
    input  logic        rw_0,
    input  logic        rw_1,
    input  logic [6:0]  addr_0,
    input  logic [6:0]  addr_1,
    input  logic [7:0]  wdata_0,
    input  logic [7:0]  wdata_1,
    output logic        done_0,
    output logic        done_1,
    output logic [7:0]  rdata_0,
    output logic [7:0]  rdata_1,
    output logic        err_0,
    output logic        err_1,
    output logic        spi_cmd_push,
    output logic [1:0]  spi_rw,
    output logic [15:0] spi_wait,
    output logic        spi_tx_push,
    output logic [7:0]  spi_tx_data,
    output logic        spi_rx_pop,
    input  logic [7:0]  spi_rx_data,
    input  logic        spi_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_START,
        S_WAIT_END,
        S_RX_POP,
        S_RX_CAP,
        S_FINISH
    } state_t;

    localparam logic [1:0]  CMD_TX  = 2'b01;
    localparam logic [1:0]  CMD_RX  = 2'b10;
    localparam logic [15:0] TO_LAST = 16'(START_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        port_q, port_d;
    logic        rw_q, rw_d;
    logic [6:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [1:0]  step_q, step_d;
    logic [15:0] cnt_q, cnt_d;
    logic        cmd_push_q, cmd_push_d;
    logic [1:0]  spi_rw_q, spi_rw_d;
    logic        tx_push_q, tx_push_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        rx_pop_q, rx_pop_d;
    logic        done_0_q, done_0_d;
    logic        done_1_q, done_1_d;
    logic        err_0_q, err_0_d;
    logic        err_1_q, err_1_d;
    logic [7:0]  rdata_0_q, rdata_0_d;
    logic [7:0]  rdata_1_q, rdata_1_d;

    logic        grant_port;
    logic [1:0]  next_step;
    logic [1:0]  last_step;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        step_d       = step_q;
        cnt_d        = cnt_q;
        cmd_push_d   = 1'b0;
        spi_rw_d     = 2'b00;
        tx_push_d    = 1'b0;
        tx_data_d    = 8'h00;
        rx_pop_d     = 1'b0;
        done_0_d     = 1'b0;
        done_1_d     = 1'b0;
        err_0_d      = 1'b0;
        err_1_d      = 1'b0;
        rdata_0_d    = rdata_0_q;
        rdata_1_d    = rdata_1_q;
        grant_port   = (req_0 && req_1) ? ~last_grant_q : req_1;
        next_step    = step_q + 2'd1;
        last_step    = rw_q ? 2'd2 : 2'd3;

        case (state_q)
            S_IDLE: begin
                // Busy high here means a frame orphaned by reset is still draining.
                if (!spi_busy && (req_0 || req_1)) begin
                    port_d    = grant_port;
                    rw_d      = grant_port ? rw_1 : rw_0;
                    addr_d    = grant_port ? addr_1 : addr_0;
                    wdata_d   = grant_port ? wdata_1 : wdata_0;
                    step_d    = 2'd0;
                    tx_push_d = 1'b1;
                    tx_data_d = {rw_d, addr_d};
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                // The strobe visible now is push step_q; schedule push step_q+1.
                if (step_q == last_step) begin
                    cnt_d   = 16'd1;
                    state_d = S_WAIT_START;
                end else begin
                    step_d = next_step;
                    if (!rw_q && next_step == 2'd1) begin
                        tx_push_d = 1'b1;
                        tx_data_d = wdata_q;
                    end else begin
                        cmd_push_d = 1'b1;
                        spi_rw_d   = (rw_q && next_step == 2'd2) ? CMD_RX : CMD_TX;
                    end
                end
            end
            S_WAIT_START: begin
                if (spi_busy) begin
                    state_d = S_WAIT_END;
                end else if (cnt_q >= TO_LAST) begin
                    done_0_d = ~port_q;
                    done_1_d = port_q;
                    err_0_d  = ~port_q;
                    err_1_d  = port_q;
                    state_d  = S_FINISH;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_WAIT_END: begin
                if (!spi_busy) begin
                    if (rw_q) begin
                        rx_pop_d = 1'b1;
                        state_d  = S_RX_POP;
                    end else begin
                        done_0_d = ~port_q;
                        done_1_d = port_q;
                        state_d  = S_FINISH;
                    end
                end
            end
            S_RX_POP: begin
                state_d = S_RX_CAP;
            end
            S_RX_CAP: begin
                if (port_q) rdata_1_d = spi_rx_data;
                else        rdata_0_d = spi_rx_data;
                done_0_d = ~port_q;
                done_1_d = port_q;
                state_d  = S_FINISH;
            end
            S_FINISH: begin
                last_grant_d = port_q;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            rw_q         <= 1'b0;
            addr_q       <= 7'h00;
            wdata_q      <= 8'h00;
            step_q       <= 2'd0;
            cnt_q        <= 16'd0;
            cmd_push_q   <= 1'b0;
            spi_rw_q     <= 2'b00;
            tx_push_q    <= 1'b0;
            tx_data_q    <= 8'h00;
            rx_pop_q     <= 1'b0;
            done_0_q     <= 1'b0;
            done_1_q     <= 1'b0;
            err_0_q      <= 1'b0;
            err_1_q      <= 1'b0;
            rdata_0_q    <= 8'h00;
            rdata_1_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            step_q       <= step_d;
            cnt_q        <= cnt_d;
            cmd_push_q   <= cmd_push_d;
            spi_rw_q     <= spi_rw_d;
            tx_push_q    <= tx_push_d;
            tx_data_q    <= tx_data_d;
            rx_pop_q     <= rx_pop_d;
            done_0_q     <= done_0_d;
            done_1_q     <= done_1_d;
            err_0_q      <= err_0_d;
            err_1_q      <= err_1_d;
            rdata_0_q    <= rdata_0_d;
            rdata_1_q    <= rdata_1_d;
        end
    end

    assign done_0       = done_0_q;
    assign done_1       = done_1_q;
    assign err_0        = err_0_q;
    assign err_1        = err_1_q;
    assign rdata_0      = rdata_0_q;
    assign rdata_1      = rdata_1_q;
    assign spi_cmd_push = cmd_push_q;
    assign spi_rw       = spi_rw_q;
    assign spi_wait     = WAIT_CYCLES;
    assign spi_tx_push  = tx_push_q;
    assign spi_tx_data  = tx_data_q;
    assign spi_rx_pop   = rx_pop_q;

endmodule

// File: tb/tb_lens_spi_sequencer.sv
// Directed bench for lens_spi_sequencer with a behavioural SPI driver model (FIFOs, busy, MISO).
module tb_lens_spi_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_0 = 1'b0, req_1 = 1'b0;
    logic        rw_0 = 1'b0, rw_1 = 1'b0;
    logic [6:0]  addr_0 = 7'h00, addr_1 = 7'h00;
    logic [7:0]  wdata_0 = 8'h00, wdata_1 = 8'h00;
    logic        done_0, done_1, err_0, err_1;
    logic [7:0]  rdata_0, rdata_1;
    logic        spi_cmd_push, spi_tx_push, spi_rx_pop;
    logic [1:0]  spi_rw;
    logic [15:0] spi_wait;
    logic [7:0]  spi_tx_data;
    logic [7:0]  spi_rx_data;
    logic        spi_busy;

    lens_spi_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .req_0(req_0), .req_1(req_1), .rw_0(rw_0), .rw_1(rw_1),
        .addr_0(addr_0), .addr_1(addr_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
        .done_0(done_0), .done_1(done_1), .rdata_0(rdata_0), .rdata_1(rdata_1),
        .err_0(err_0), .err_1(err_1),
        .spi_cmd_push(spi_cmd_push), .spi_rw(spi_rw), .spi_wait(spi_wait),
        .spi_tx_push(spi_tx_push), .spi_tx_data(spi_tx_data),
        .spi_rx_pop(spi_rx_pop), .spi_rx_data(spi_rx_data), .spi_busy(spi_busy)
    );

    always #5 clk = ~clk;

    // ---------------- driver model ----------------
    logic       dead = 1'b0;
    logic       mbusy = 1'b0;
    logic [3:0] start_cnt = 4'd0;
    logic [4:0] bit_tmr = 5'd0;
    logic [7:0] mrx = 8'h00;
    logic [6:0] cur_addr = 7'h00;
    logic [7:0] tx_q[$];
    logic [1:0] cmd_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] mosi[0:63];
    int         mosi_n = 0;

    assign spi_busy    = mbusy;
    assign spi_rx_data = mrx;

    function automatic logic [7:0] miso_of(input logic [6:0] a);
        case (a)
            7'h05:   return 8'h3C;
            7'h21:   return 8'h9E;
            default: return {1'b0, a} ^ 8'h5A;
        endcase
    endfunction

    always @(posedge clk) begin
        if (spi_tx_push && !dead) tx_q.push_back(spi_tx_data);
        if (spi_cmd_push && !dead) cmd_q.push_back(spi_rw);
        if (spi_rx_pop && rx_q.size() > 0) mrx <= rx_q.pop_front();
        if (!mbusy) begin
            if (start_cnt != 4'd0) begin
                if (start_cnt == 4'd1) begin
                    mbusy   <= 1'b1;
                    bit_tmr <= 5'd10;
                end
                start_cnt <= start_cnt - 4'd1;
            end else if (spi_cmd_push && !dead) begin
                start_cnt <= 4'd2;
            end
        end else if (bit_tmr != 5'd0) begin
            bit_tmr <= bit_tmr - 5'd1;
        end else if (cmd_q.size() > 0) begin
            if (cmd_q[0] == 2'b01 && tx_q.size() > 0) begin
                mosi[mosi_n[5:0]] <= tx_q[0];
                mosi_n            <= mosi_n + 1;
                cur_addr          <= tx_q[0][6:0];
                void'(tx_q.pop_front());
            end else if (cmd_q[0] == 2'b10) begin
                rx_q.push_back(miso_of(cur_addr));
            end
            void'(cmd_q.pop_front());
            if (cmd_q.size() == 0) mbusy <= 1'b0;
            else                   bit_tmr <= 5'd10;
        end else begin
            mbusy <= 1'b0;
        end
    end

    // ---------------- monitor (samples on negedge) ----------------
    int         cyc = 0;
    logic [9:0] log_dat[0:255];
    int         log_cyc[0:255];
    int         log_n = 0;
    int         pop_n = 0;
    int         busy_rises = 0;
    int         last_hi = 0;
    int         done_cyc = 0;
    int         multi = 0;
    logic       prev_busy = 1'b0;

    always @(negedge clk) begin
        cyc       <= cyc + 1;
        prev_busy <= spi_busy;
        if (spi_busy) last_hi <= cyc;
        if (spi_busy && !prev_busy) busy_rises <= busy_rises + 1;
        if (done_0 || done_1) done_cyc <= cyc;
        if (spi_rx_pop) pop_n <= pop_n + 1;
        if (32'(spi_tx_push) + 32'(spi_cmd_push) + 32'(spi_rx_pop) > 1) multi <= multi + 1;
        if (spi_tx_push) begin
            log_dat[log_n[7:0]] <= {2'b01, spi_tx_data};
            log_cyc[log_n[7:0]] <= cyc;
            log_n               <= log_n + 1;
        end else if (spi_cmd_push) begin
            log_dat[log_n[7:0]] <= {2'b10, 6'b0, spi_rw};
            log_cyc[log_n[7:0]] <= cyc;
            log_n               <= log_n + 1;
        end
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_miss = 0;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int port, output int dcyc);
        bit got = 1'b0;
        for (int k = 0; k < 3000 && !got; k++) begin
            step();
            if ((port == 0 && done_0) || (port == 1 && done_1)) got = 1'b1;
        end
        if (!got) check_vec("done_wait_expired", 32'd0, 32'd1);
        dcyc = done_cyc;
    endtask

    task automatic run_txn(input int port, input logic rw, input logic [6:0] a,
                           input logic [7:0] wd, output int dcyc, output logic derr);
        if (port == 0) begin rw_0 = rw; addr_0 = a; wdata_0 = wd; req_0 = 1'b1; end
        else           begin rw_1 = rw; addr_1 = a; wdata_1 = wd; req_1 = 1'b1; end
        wait_done(port, dcyc);
        derr  = (port == 0) ? err_0 : err_1;
        req_0 = (port == 0) ? 1'b0 : req_0;
        req_1 = (port == 1) ? 1'b0 : req_1;
    endtask

    int   base, mbase, pbase, brise, dc, early, nd;
    logic de;
    int   ord[0:3];
    logic [9:0] exp_wr[0:3];
    logic [9:0] exp_rd[0:2];

    initial begin
        exp_wr[0] = 10'h112; exp_wr[1] = 10'h1A5; exp_wr[2] = 10'h201; exp_wr[3] = 10'h201;
        exp_rd[0] = 10'h185; exp_rd[1] = 10'h201; exp_rd[2] = 10'h202;

        repeat (3) step();
        check_vec("rst_strobes", {spi_cmd_push, spi_tx_push, spi_rx_pop, done_0, done_1, err_0, err_1}, 0);
        check_vec("rst_rdata", {rdata_0, rdata_1}, 16'h0000);
        check_vec("rst_rw_txdata", {spi_rw, spi_tx_data}, 10'h000);
        check_vec("rst_wait", spi_wait, 16'd4);
        rst_n = 1'b1;
        step();

        // port-0 write 12/A5
        base = log_n; mbase = mosi_n;
        run_txn(0, 1'b0, 7'h12, 8'hA5, dc, de);
        check_vec("wr_err", de, 0);
        check_vec("wr_lat", dc - last_hi, 2);
        check_vec("wr_npush", log_n - base, 4);
        for (int i = 0; i < 4; i++) check_vec($sformatf("wr_push%0d", i), log_dat[base + i], exp_wr[i]);
        check_vec("wr_push_gap", log_cyc[base + 3] - log_cyc[base], 3);
        check_vec("wr_mosi", {mosi[mbase], mosi[mbase + 1]}, 16'h12A5);
        step();
        check_vec("wr_done_pulse", done_0, 0);

        // port-1 read 05 -> 3C
        base = log_n; mbase = mosi_n; pbase = pop_n;
        run_txn(1, 1'b1, 7'h05, 8'h00, dc, de);
        step();
        check_vec("rd_err", de, 0);
        check_vec("rd_rdata", rdata_1, 8'h3C);
        check_vec("rd_lat", dc - last_hi, 4);
        check_vec("rd_npush", log_n - base, 3);
        for (int i = 0; i < 3; i++) check_vec($sformatf("rd_push%0d", i), log_dat[base + i], exp_rd[i]);
        check_vec("rd_mosi", mosi[mbase], 8'h85);
        check_vec("rd_pops", pop_n - pbase, 1);

        // tie: port 0 reads 21, port 1 writes 33/77
        rw_0 = 1'b1; addr_0 = 7'h21; rw_1 = 1'b0; addr_1 = 7'h33; wdata_1 = 8'h77;
        brise = busy_rises; mbase = mosi_n; nd = 0;
        req_0 = 1'b1; req_1 = 1'b1;
        for (int k = 0; k < 4000 && nd < 4; k++) begin
            step();
            if (done_0 || done_1) begin
                ord[nd] = done_1 ? 1 : 0;
                nd++;
            end
        end
        req_0 = 1'b0; req_1 = 1'b0;
        check_vec("tie_ndone", nd, 4);
        for (int i = 0; i < 4; i++) check_vec($sformatf("tie_grant%0d", i), ord[i], i % 2);
        step(); step();
        check_vec("tie_busy_periods", busy_rises - brise, 4);
        check_vec("tie_mosi_bytes", mosi_n - mbase, 6);
        check_vec("tie_rdata0", rdata_0, 8'h9E);

        // start timeout on a port-0 read
        dead = 1'b1; pbase = pop_n;
        run_txn(0, 1'b1, 7'h10, 8'h00, dc, de);
        check_vec("to_err", de, 1);
        check_vec("to_lat", dc - log_cyc[log_n - 1], 16);
        step();
        check_vec("to_no_pop", pop_n - pbase, 0);
        check_vec("to_rdata_kept", rdata_0, 8'h9E);
        dead = 1'b0;
        repeat (3) step();

        // reset mid-frame during a port-1 read of 21
        rw_1 = 1'b1; addr_1 = 7'h21; req_1 = 1'b1;
        for (int k = 0; k < 200 && !spi_busy; k++) step();
        check_vec("mr_busy_seen", spi_busy, 1);
        rst_n = 1'b0; addr_1 = 7'h05;
        step();
        check_vec("mr_rst_strobes", {spi_cmd_push, spi_tx_push, spi_rx_pop, done_0, done_1, err_0, err_1}, 0);
        check_vec("mr_rst_rdata", {rdata_0, rdata_1, spi_rw, spi_tx_data}, 26'h0);
        rst_n = 1'b1;
        early = 0;
        for (int k = 0; k < 300 && spi_busy; k++) begin
            if (spi_tx_push || spi_cmd_push) early++;
            step();
        end
        check_vec("mr_busy_fell", spi_busy, 0);
        check_vec("mr_no_early_grant", early, 0);
        wait_done(1, dc);
        req_1 = 1'b0;
        step();
        check_vec("mr_dummy_stale", rdata_1, 8'h9E);
        run_txn(1, 1'b1, 7'h05, 8'h00, dc, de);
        step();
        check_vec("mr_read_ok", rdata_1, 8'h3C);
        check_vec("one_strobe_per_cycle", multi, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
